// File: rtl/sr_fetch_queue_if.sv
// Fetch -> decode queue bus: fetch/decode side is master, the queue is slave.
// Parameters must match those of the sr_fetch_queue instance it connects to.
interface sr_fetch_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush_i;
    logic               push_valid_i;
    logic               push_ready_o;
    logic [ADDR_W-1:0]  push_pc_i;
    logic [INSTR_W-1:0] push_instr_i;
    logic               pop_valid_o;
    logic               pop_ready_i;
    logic [ADDR_W-1:0]  pop_pc_o;
    logic [INSTR_W-1:0] pop_instr_o;
    logic [CNT_W-1:0]   count_o;

    modport master (
        output flush_i, push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, count_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, count_o
    );
endinterface

// File: rtl/sr_fetch_queue.sv
// Fetch queue buffering {pc, instr} pairs between fetch and decode; shows a NOP bubble when empty.
// Optional same-cycle push->pop bypass on an empty queue: define SR_FETCH_QUEUE_BYPASS_EN.
module sr_fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    sr_fetch_queue_if.slave  q
);
    localparam int unsigned         PTR_W    = $clog2(DEPTH);
    localparam int unsigned         CNT_W    = PTR_W + 1;
    localparam logic [INSTR_W-1:0]  NOP      = INSTR_W'(32'h0000_0013);
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  memPc    [DEPTH];
    logic [INSTR_W-1:0] memInstr [DEPTH];

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic pushReady;
    logic popValid;
    logic pushFire;
    logic popFire;
    logic bypass;
    logic wrEn;
    logic rdEn;

    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        pushReady = ~full & ~q.flush_i;
`ifdef SR_FETCH_QUEUE_BYPASS_EN
        bypass    = empty & q.push_valid_i & ~q.flush_i;
`else
        bypass    = 1'b0;
`endif
        popValid  = ~empty | bypass;
        pushFire  = q.push_valid_i & pushReady;
        popFire   = popValid & q.pop_ready_i;
        // A bypassed entry consumed this cycle never touches storage.
        wrEn      = pushFire & ~(bypass & popFire);
        rdEn      = popFire & ~empty;
    end

    always_comb begin
        q.push_ready_o = pushReady;
        q.pop_valid_o  = popValid;
        q.count_o      = count;
        q.pop_pc_o     = '0;
        q.pop_instr_o  = NOP;
        if (bypass) begin
            q.pop_pc_o    = q.push_pc_i;
            q.pop_instr_o = q.push_instr_i;
        end else if (!empty) begin
            q.pop_pc_o    = memPc[rdPtr];
            q.pop_instr_o = memInstr[rdPtr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (q.flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn)
                wrPtr <= wrPtr + PTR_W'(1);
            if (rdEn)
                rdPtr <= rdPtr + PTR_W'(1);
            case ({wrEn, rdEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count/pointers gate its visibility.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            memPc[wrPtr]    <= q.push_pc_i;
            memInstr[wrPtr] <= q.push_instr_i;
        end
    end
endmodule

// File: tb/tb_sr_fetch_queue.sv
// Self-checking bench for sr_fetch_queue (DEPTH=4): vector table plus reset, wrap and bypass sequences.
// Expectations follow SR_FETCH_QUEUE_BYPASS_EN when the bench is built with it defined.
module tb_sr_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        flush;
        logic        pushValid;
        logic [31:0] pushPc;
        logic [31:0] pushInstr;
        logic        popReady;
        logic        expPushReady;
        logic        expPopValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [2:0]  expCount;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    sr_fetch_queue_if #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) bus ();

    sr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic pv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic pr);
        bus.flush_i      = fl;
        bus.push_valid_i = pv;
        bus.push_pc_i    = pc;
        bus.push_instr_i = ins;
        bus.pop_ready_i  = pr;
    endtask

    vec_t        vecs [21];
    logic [63:0] model [$];
    logic [63:0] expHead;
    logic        ePv;
    logic [31:0] ePc;
    logic [31:0] eIn;
    logic        pf;
    logic        qf;
    int          nPushed;
    int          nGot;
    logic        popTog;

    initial begin
        //          fl pv pushPc  pushInstr     pr  pRdy pVal expPc   expInstr     cnt
        vecs[0]  = '{1'b0,1'b1,32'h00,32'h00500593,1'b0, 1'b1,1'b0,32'h00,NOP,         3'd0};
        vecs[1]  = '{1'b0,1'b1,32'h04,32'h00b50533,1'b0, 1'b1,1'b1,32'h00,32'h00500593,3'd1};
        vecs[2]  = '{1'b0,1'b1,32'h08,32'h00c58633,1'b0, 1'b1,1'b1,32'h00,32'h00500593,3'd2};
        vecs[3]  = '{1'b0,1'b1,32'h0C,32'h00d60693,1'b0, 1'b1,1'b1,32'h00,32'h00500593,3'd3};
        vecs[4]  = '{1'b0,1'b1,32'h10,32'h11111113,1'b0, 1'b0,1'b1,32'h00,32'h00500593,3'd4};
        vecs[5]  = '{1'b0,1'b0,32'h00,32'h00000000,1'b1, 1'b0,1'b1,32'h00,32'h00500593,3'd4};
        vecs[6]  = '{1'b0,1'b0,32'h00,32'h00000000,1'b1, 1'b1,1'b1,32'h04,32'h00b50533,3'd3};
        vecs[7]  = '{1'b0,1'b0,32'h00,32'h00000000,1'b1, 1'b1,1'b1,32'h08,32'h00c58633,3'd2};
        vecs[8]  = '{1'b0,1'b0,32'h00,32'h00000000,1'b1, 1'b1,1'b1,32'h0C,32'h00d60693,3'd1};
        vecs[9]  = '{1'b0,1'b0,32'h00,32'h00000000,1'b0, 1'b1,1'b0,32'h00,NOP,         3'd0};
        vecs[10] = '{1'b0,1'b1,32'h20,32'h0a000013,1'b0, 1'b1,1'b0,32'h00,NOP,         3'd0};
        vecs[11] = '{1'b0,1'b1,32'h24,32'h0b000013,1'b0, 1'b1,1'b1,32'h20,32'h0a000013,3'd1};
        vecs[12] = '{1'b0,1'b1,32'h28,32'h0c000013,1'b1, 1'b1,1'b1,32'h20,32'h0a000013,3'd2};
        vecs[13] = '{1'b0,1'b0,32'h00,32'h00000000,1'b0, 1'b1,1'b1,32'h24,32'h0b000013,3'd2};
        vecs[14] = '{1'b0,1'b1,32'h2C,32'h0d000013,1'b0, 1'b1,1'b1,32'h24,32'h0b000013,3'd2};
        vecs[15] = '{1'b0,1'b1,32'h30,32'h0e000013,1'b0, 1'b1,1'b1,32'h24,32'h0b000013,3'd3};
        vecs[16] = '{1'b0,1'b1,32'h34,32'h0f000013,1'b1, 1'b0,1'b1,32'h24,32'h0b000013,3'd4};
        vecs[17] = '{1'b0,1'b0,32'h00,32'h00000000,1'b0, 1'b1,1'b1,32'h28,32'h0c000013,3'd3};
        vecs[18] = '{1'b1,1'b1,32'h38,32'h07700013,1'b0, 1'b0,1'b1,32'h28,32'h0c000013,3'd3};
        vecs[19] = '{1'b0,1'b0,32'h00,32'h00000000,1'b0, 1'b1,1'b0,32'h00,NOP,         3'd0};
        vecs[20] = '{1'b0,1'b0,32'h00,32'h00000000,1'b1, 1'b1,1'b0,32'h00,NOP,         3'd0};

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("rst.count", 64'(bus.count_o), 64'd0);
        check("rst.popValid", 64'(bus.pop_valid_o), 64'd0);
        check("rst.pc", 64'(bus.pop_pc_o), 64'd0);
        check("rst.instr", 64'(bus.pop_instr_o), 64'(NOP));
        check("rst.pushReady", 64'(bus.push_ready_o), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset asserted mid-cycle with two entries queued.
        drive(1'b0, 1'b1, 32'h40, 32'h00100093, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h44, 32'h00200093, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("midrst.countBefore", 64'(bus.count_o), 64'd2);
        rst = 1'b1;
        #1;
        check("midrst.count", 64'(bus.count_o), 64'd0);
        check("midrst.popValid", 64'(bus.pop_valid_o), 64'd0);
        check("midrst.instr", 64'(bus.pop_instr_o), 64'(NOP));
        check("midrst.pc", 64'(bus.pop_pc_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill/drain, simultaneous push+pop, full refusal, flush.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].pushValid, vecs[i].pushPc, vecs[i].pushInstr, vecs[i].popReady);
            #2;
            ePv = vecs[i].expPopValid;
            ePc = vecs[i].expPc;
            eIn = vecs[i].expInstr;
`ifdef SR_FETCH_QUEUE_BYPASS_EN
            if (vecs[i].expCount == 3'd0 && vecs[i].pushValid && !vecs[i].flush) begin
                ePv = 1'b1;
                ePc = vecs[i].pushPc;
                eIn = vecs[i].pushInstr;
            end
`endif
            check($sformatf("vec%0d.count", i), 64'(bus.count_o), 64'(vecs[i].expCount));
            check($sformatf("vec%0d.pushReady", i), 64'(bus.push_ready_o), 64'(vecs[i].expPushReady));
            check($sformatf("vec%0d.popValid", i), 64'(bus.pop_valid_o), 64'(ePv));
            check($sformatf("vec%0d.pc", i), 64'(bus.pop_pc_o), 64'(ePc));
            check($sformatf("vec%0d.instr", i), 64'(bus.pop_instr_o), 64'(eIn));
        end

        // Wrap-around: 10 entries, push every cycle, pop_ready toggling 1,0.
        nPushed = 0;
        nGot    = 0;
        popTog  = 1'b1;
        for (int cyc = 0; cyc < 60 && nGot < 10; cyc++) begin
            @(negedge clk);
            drive(1'b0, (nPushed < 10), 32'h100 + 32'(nPushed) * 4,
                  NOP | (32'(nPushed) << 20), popTog);
            popTog = ~popTog;
            #2;
            check($sformatf("wrap%0d.count", cyc), 64'(bus.count_o), 64'(model.size()));
            check($sformatf("wrap%0d.pushReady", cyc), 64'(bus.push_ready_o), 64'(model.size() != 4));
            pf = bus.push_valid_i & bus.push_ready_o;
            qf = bus.pop_valid_o & bus.pop_ready_i;
            if (pf)
                model.push_back({bus.push_pc_i, bus.push_instr_i});
            if (qf) begin
                expHead = (model.size() > 0) ? model.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                check($sformatf("wrap.entry%0d", nGot), {bus.pop_pc_o, bus.pop_instr_o}, expHead);
                nGot++;
            end
            if (pf)
                nPushed++;
        end
        check("wrap.received", 64'(nGot), 64'd10);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("wrap.finalCount", 64'(bus.count_o), 64'd0);

        // Empty queue, push with pop_ready high.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h10, 32'h00100093, 1'b1);
        #2;
`ifdef SR_FETCH_QUEUE_BYPASS_EN
        check("byp.popValid", 64'(bus.pop_valid_o), 64'd1);
        check("byp.pc", 64'(bus.pop_pc_o), 64'h10);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("byp.countAfter", 64'(bus.count_o), 64'd0);
        check("byp.popValidAfter", 64'(bus.pop_valid_o), 64'd0);
`else
        check("byp.popValid", 64'(bus.pop_valid_o), 64'd0);
        check("byp.pc", 64'(bus.pop_pc_o), 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        check("byp.countAfter", 64'(bus.count_o), 64'd1);
        check("byp.pcAfter", 64'(bus.pop_pc_o), 64'h10);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        check("byp.drained", 64'(bus.count_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
